mmu_port: RTL and testbench
===========================

// Module: mmu_port
// PURPOSE
//  Memory-side responder to the control path's fetch/load/store handshake. Accepts instruction-fetch
//  and data ld/st requests, bounds-checks and relocates them against one segment (base/limit), runs
//  one access at a time on a single-ported memory bus, and returns data or a segfault.
//  Drives wait_instr/wait_data while busy and instr_segv/data_segv on faults.
// PARAMETERS
//  TIMEOUT   16  cycles in an ACCESS state without mem_ready before the access faults (>=2)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  instr_req    in   1   fetch request, held until wait_instr low
//  pc           in   32  fetch virtual address
//  instruction  out  32  fetched word, valid while state==DONE_I
//  wait_instr   out  1   fetch in progress
//  instr_segv   out  1   fetch fault, held until instr_req drops
//  ld / st      in   1   data load / store request, held until wait_data low; both high = store
//  data_addr    in   32  data virtual address
//  wdata        in   32  store data
//  rdata        out  32  load data, valid while state==DONE_D
//  wait_data    out  1   data access in progress
//  data_segv    out  1   data fault, held until ld|st drops
//  seg_base     in   32  physical base, sampled at request acceptance
//  seg_limit    in   32  segment size in bytes
//  mem_addr     out  32  physical address
//  mem_wdata    out  32  write data
//  mem_re       out  1   read strobe, held until mem_ready
//  mem_we       out  1   write strobe, held until mem_ready
//  mem_rdata    in   32  read data, valid with mem_ready
//  mem_ready    in   1   access complete
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 incl. instruction, rdata, mem_addr; timeout counter 0.
//  Reset asserted mid-access: mem_re/mem_we drop asynchronously; pending access discarded.
//  Legal access: vaddr < seg_limit (unsigned); paddr = seg_base + vaddr mod 2^32.
//  States: IDLE, ACC_I, ACC_D, DONE_I, DONE_D, FAULT_I, FAULT_D.
//  IDLE: ld|st has priority over instr_req when both present; losing fetch stays pending.
//   Legal -> ACC_D/ACC_I next edge, latching paddr, wdata, direction. Illegal -> FAULT_D/FAULT_I.
//  ACC_x: mem_re or mem_we high, mem_addr/mem_wdata stable. mem_ready: load/fetch capture mem_rdata
//   -> DONE_x. Counter reaches TIMEOUT-1 without mem_ready -> FAULT_x; strobes drop same edge.
//  DONE_x: wait low, data valid; stays until request drops -> IDLE (no re-issue while held).
//  FAULT_x: segv high, wait low; -> IDLE when request drops.
//  wait_data = (ld|st) & state not in {DONE_D, FAULT_D}; wait_instr likewise with instr_req.
//   Combinational: high in the same cycle a request appears in IDLE.
//  Latency: legal access, mem_ready on first ACC cycle -> wait low 2 cycles after request.
//  seg_base/seg_limit changes during an access do not affect it.
//  instruction/rdata hold last captured value outside DONE (not cleared).
// CONFIGURATION
//  MMU_ALIGN_CHECK_EN defined: vaddr[1:0]!=0 is illegal (fault, no bus access).
//  Undefined: low bits ignored; mem_addr is paddr unmodified.
// STRUCTURE
//  Package mmu_pkg: state enum, ADDR_W=32, DATA_W=32, TIMEOUT_W (counter width).
//  Sub-module mmu_bounds_check (combinational: vaddr, base, limit -> paddr, legal; align rule when
//  macro set), instantiated twice (fetch and data) so arbitration sees both verdicts in IDLE.
// TESTING
//  base=0x1000, limit=0x100, ld addr 0x10, mem_ready after 3 cycles, mem_rdata=0xDEADBEEF
//   -> mem_addr=0x1010, mem_re 3 cycles, rdata=0xDEADBEEF, wait_data low in DONE_D, no segv.
//  st addr 0x100 (==limit) -> data_segv next cycle, mem_we never high, clears when st drops.
//  instr_req and ld same cycle -> load serviced first, wait_instr high throughout, then fetch issued.
//  TIMEOUT=16, mem_ready stuck low -> mem_re high exactly 16 cycles, then data_segv, mem_re 0.
//  reset_n low during ACC_D -> mem_re/mem_we 0 immediately; after release IDLE, all outputs 0.
//  MMU_ALIGN_CHECK_EN: ld addr 0x2 -> data_segv, no bus access; without macro -> mem_addr=base+2.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared types and widths for the mmu_port memory-side responder.
package mmu_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ACC_I,
        ACC_D,
        DONE_I,
        DONE_D,
        FAULT_I,
        FAULT_D
    } state_e;

endpackage

// File: rtl/mmu_bounds_check.sv
// Segment check and relocation for one virtual address.
// With MMU_ALIGN_CHECK_EN defined, word-misaligned addresses are also rejected.
module mmu_bounds_check
    import mmu_pkg::*;
(
    input  logic [ADDR_W-1:0] vaddr_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] limit_i,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              legal_o
);

    // Relocation wraps modulo 2^32 by construction of the adder width.
    assign paddr_o = base_i + vaddr_i;

`ifdef MMU_ALIGN_CHECK_EN
    assign legal_o = (vaddr_i < limit_i) && (vaddr_i[1:0] == 2'b00);
`else
    assign legal_o = (vaddr_i < limit_i);
`endif

endmodule

// File: rtl/mmu_port.sv
// Memory-side responder for fetch/load/store: bounds-checks, relocates and runs one
// access at a time on a single-ported bus. Optional alignment faults via MMU_ALIGN_CHECK_EN.
module mmu_port
    import mmu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    output logic              wait_instr,
    output logic              instr_segv,
    input  logic              ld,
    input  logic              st,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              wait_data,
    output logic              data_segv,
    input  logic [ADDR_W-1:0] seg_base,
    input  logic [ADDR_W-1:0] seg_limit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 is_store_q, is_store_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]    instr_q, instr_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic                 data_req;
    logic [ADDR_W-1:0]    i_paddr, d_paddr;
    logic                 i_legal, d_legal;

    assign data_req = ld | st;

    // Both verdicts are available in IDLE so arbitration needs no extra cycle.
    mmu_bounds_check u_chk_fetch (
        .vaddr_i (pc),
        .base_i  (seg_base),
        .limit_i (seg_limit),
        .paddr_o (i_paddr),
        .legal_o (i_legal)
    );

    mmu_bounds_check u_chk_data (
        .vaddr_i (data_addr),
        .base_i  (seg_base),
        .limit_i (seg_limit),
        .paddr_o (d_paddr),
        .legal_o (d_legal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            instr_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            instr_q     <= instr_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_store_d  = is_store_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;

        case (state_q)
            IDLE: begin
                // Data side wins; a concurrent fetch simply stays pending.
                if (data_req) begin
                    if (d_legal) begin
                        state_d     = ACC_D;
                        cnt_d       = '0;
                        is_store_d  = st;
                        mem_addr_d  = d_paddr;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = FAULT_D;
                    end
                end else if (instr_req) begin
                    if (i_legal) begin
                        state_d    = ACC_I;
                        cnt_d      = '0;
                        is_store_d = 1'b0;
                        mem_addr_d = i_paddr;
                    end else begin
                        state_d = FAULT_I;
                    end
                end
            end
            ACC_I: begin
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    state_d = DONE_I;
                end else if (cnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
                    state_d = FAULT_I;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            ACC_D: begin
                if (mem_ready) begin
                    if (!is_store_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE_D;
                end else if (cnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
                    state_d = FAULT_D;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            DONE_I, FAULT_I: begin
                if (!instr_req) begin
                    state_d = IDLE;
                end
            end
            DONE_D, FAULT_D: begin
                if (!data_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from the registered state so an async reset removes them at once.
    assign mem_re      = (state_q == ACC_I) || ((state_q == ACC_D) && !is_store_q);
    assign mem_we      = (state_q == ACC_D) && is_store_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign instruction = instr_q;
    assign rdata       = rdata_q;

    assign wait_data   = data_req && !((state_q == DONE_D) || (state_q == FAULT_D));
    assign wait_instr  = instr_req && !((state_q == DONE_I) || (state_q == FAULT_I));
    assign data_segv   = (state_q == FAULT_D);
    assign instr_segv  = (state_q == FAULT_I);

endmodule

// File: tb/tb_mmu_port.sv
// Scoreboard bench for mmu_port: directed fetch/load/store vectors, bus and response monitors.
module tb_mmu_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_req = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instruction;
    logic        wait_instr;
    logic        instr_segv;
    logic        ld = 1'b0;
    logic        st = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        wait_data;
    logic        data_segv;
    logic [31:0] seg_base = '0;
    logic [31:0] seg_limit = '0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    mmu_port #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_req   (instr_req),
        .pc          (pc),
        .instruction (instruction),
        .wait_instr  (wait_instr),
        .instr_segv  (instr_segv),
        .ld          (ld),
        .st          (st),
        .data_addr   (data_addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .wait_data   (wait_data),
        .data_segv   (data_segv),
        .seg_base    (seg_base),
        .seg_limit   (seg_limit),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    typedef struct packed {
        logic        segv;
        logic        chk_data;
        logic [31:0] data;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    resp_t exp_d[$];
    resp_t exp_i[$];
    bus_t  exp_bus[$];

    int checks = 0;
    int failures = 0;
    int re_cycles = 0;
    int we_cycles = 0;
    int ready_lat = 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: mem_ready after ready_lat strobe cycles (0 = never).
    initial begin : responder
        int acc_cnt;
        acc_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_re || mem_we) begin
                acc_cnt++;
                mem_ready = (ready_lat != 0) && (acc_cnt == ready_lat);
            end else begin
                acc_cnt   = 0;
                mem_ready = 1'b0;
            end
            mem_rdata = (mem_addr == 32'h0000_1010) ? 32'hDEAD_BEEF : ~mem_addr;
        end
    end

    // Monitor: bus handshakes and request completions are popped against the queues.
    logic d_prev = 1'b0;
    logic i_prev = 1'b0;
    always @(negedge clk) begin
        logic  dc;
        logic  ic;
        bus_t  b;
        resp_t r;
        if (mem_re) re_cycles++;
        if (mem_we) we_cycles++;
        if ((mem_re || mem_we) && mem_ready) begin
            if (exp_bus.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_unexpected: addr 0x%08h we %0b", mem_addr, mem_we);
            end else begin
                b = exp_bus.pop_front();
                check32("bus_addr", mem_addr, b.addr);
                check32("bus_we", {31'b0, mem_we}, {31'b0, b.we});
                if (b.we) check32("bus_wdata", mem_wdata, b.wdata);
            end
        end
        dc = (ld || st) && !wait_data;
        if (dc && !d_prev) begin
            if (exp_d.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL data_resp_unexpected: segv %0b rdata 0x%08h", data_segv, rdata);
            end else begin
                r = exp_d.pop_front();
                check32("data_segv", {31'b0, data_segv}, {31'b0, r.segv});
                if (r.chk_data) check32("rdata", rdata, r.data);
            end
        end
        d_prev = dc;
        ic = instr_req && !wait_instr;
        if (ic && !i_prev) begin
            if (exp_i.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL instr_resp_unexpected: segv %0b instr 0x%08h", instr_segv, instruction);
            end else begin
                r = exp_i.pop_front();
                check32("instr_segv", {31'b0, instr_segv}, {31'b0, r.segv});
                if (r.chk_data) check32("instruction", instruction, r.data);
            end
        end
        i_prev = ic;
    end

    task automatic check_all_zero(input string tag);
        check32({tag, "_wait_data"},  {31'b0, wait_data},  32'h0);
        check32({tag, "_wait_instr"}, {31'b0, wait_instr}, 32'h0);
        check32({tag, "_data_segv"},  {31'b0, data_segv},  32'h0);
        check32({tag, "_instr_segv"}, {31'b0, instr_segv}, 32'h0);
        check32({tag, "_mem_re_we"},  {30'b0, mem_re, mem_we}, 32'h0);
        check32({tag, "_mem_addr"},   mem_addr,    32'h0);
        check32({tag, "_mem_wdata"},  mem_wdata,   32'h0);
        check32({tag, "_rdata"},      rdata,       32'h0);
        check32({tag, "_instruction"}, instruction, 32'h0);
    endtask

    // Issue a data request (optionally with a simultaneous fetch), scramble the segment
    // registers once accepted, wait for wait_data low, then release the request.
    task automatic data_op(input logic is_ld, input logic is_st, input logic [31:0] addr,
                           input logic [31:0] wd, input int lat, input int exp_n,
                           input logic with_fetch, input logic [31:0] fpc);
        int n;
        int i_low;
        logic [31:0] base_s;
        logic [31:0] lim_s;
        ready_lat = lat;
        @(posedge clk);
        #1;
        ld = is_ld;
        st = is_st;
        data_addr = addr;
        wdata = wd;
        if (with_fetch) begin
            instr_req = 1'b1;
            pc = fpc;
        end
        @(negedge clk);
        check32("wait_data_same_cycle", {31'b0, wait_data}, 32'h1);
        @(posedge clk);
        #1;
        base_s = seg_base;
        lim_s = seg_limit;
        seg_base = 32'h5555_0000;
        seg_limit = 32'h0;
        n = 0;
        i_low = 0;
        while (n < 100) begin
            @(negedge clk);
            if (with_fetch && !wait_instr) i_low++;
            if (!wait_data) break;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL data_wait_timeout: still waiting after %0d cycles, expected %0d", n, exp_n);
        end else begin
            check32("data_latency", n, exp_n);
        end
        if (with_fetch) check32("wait_instr_held", i_low, 32'h0);
        @(posedge clk);
        #1;
        seg_base = base_s;
        seg_limit = lim_s;
        ld = 1'b0;
        st = 1'b0;
    endtask

    task automatic fetch_wait();
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!wait_instr) break;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL fetch_wait_timeout: wait_instr high after %0d cycles, expected low", n);
        end
        @(posedge clk);
        #1;
        instr_req = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int re0;
        int we0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        seg_base = 32'h0000_1000;
        seg_limit = 32'h0000_0100;
        @(negedge clk);
        check_all_zero("after_reset");

        // Load, mem_ready on the third strobe cycle.
        exp_bus.push_back('{addr: 32'h0000_1010, we: 1'b0, wdata: 32'h0});
        exp_d.push_back('{segv: 1'b0, chk_data: 1'b1, data: 32'hDEAD_BEEF});
        re0 = re_cycles;
        data_op(1'b1, 1'b0, 32'h10, 32'h0, 3, 3, 1'b0, 32'h0);
        check32("ld_re_cycles", re_cycles - re0, 32'd3);

        // Store at exactly the limit faults with no write strobe.
        exp_d.push_back('{segv: 1'b1, chk_data: 1'b0, data: 32'h0});
        we0 = we_cycles;
        data_op(1'b0, 1'b1, 32'h100, 32'h1234_5678, 1, 0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check32("st_fault_we_cycles", we_cycles - we0, 32'd0);
        check32("st_segv_cleared", {31'b0, data_segv}, 32'h0);

        // Load and fetch together: load first, then the fetch.
        exp_bus.push_back('{addr: 32'h0000_1020, we: 1'b0, wdata: 32'h0});
        exp_bus.push_back('{addr: 32'h0000_1040, we: 1'b0, wdata: 32'h0});
        exp_d.push_back('{segv: 1'b0, chk_data: 1'b1, data: 32'hFFFF_EFDF});
        exp_i.push_back('{segv: 1'b0, chk_data: 1'b1, data: 32'hFFFF_EFBF});
        data_op(1'b1, 1'b0, 32'h20, 32'h0, 1, 1, 1'b1, 32'h40);
        fetch_wait();

        // Bus never answers: exactly 16 read-strobe cycles, then a fault.
        exp_d.push_back('{segv: 1'b1, chk_data: 1'b1, data: 32'hFFFF_EFDF});
        re0 = re_cycles;
        data_op(1'b1, 1'b0, 32'h30, 32'h0, 0, 16, 1'b0, 32'h0);
        check32("timeout_re_cycles", re_cycles - re0, 32'd16);
        @(negedge clk);
        check32("timeout_re_dropped", {31'b0, mem_re}, 32'h0);
        @(posedge clk);

        // Asynchronous reset in the middle of a load.
        ready_lat = 0;
        @(posedge clk);
        #1;
        ld = 1'b1;
        data_addr = 32'h44;
        repeat (3) @(posedge clk);
        #3;
        check32("pre_reset_re", {31'b0, mem_re}, 32'h1);
        reset_n = 1'b0;
        #1;
        check32("async_reset_strobes", {30'b0, mem_re, mem_we}, 32'h0);
        ld = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");

        // Misaligned load: fault with the alignment check, relocated access without.
`ifdef MMU_ALIGN_CHECK_EN
        exp_d.push_back('{segv: 1'b1, chk_data: 1'b1, data: 32'h0});
        re0 = re_cycles;
        data_op(1'b1, 1'b0, 32'h2, 32'h0, 1, 0, 1'b0, 32'h0);
        check32("misalign_re_cycles", re_cycles - re0, 32'd0);
`else
        exp_bus.push_back('{addr: 32'h0000_1002, we: 1'b0, wdata: 32'h0});
        exp_d.push_back('{segv: 1'b0, chk_data: 1'b1, data: 32'hFFFF_EFFD});
        data_op(1'b1, 1'b0, 32'h2, 32'h0, 1, 1, 1'b0, 32'h0);
`endif

        // Store with address wrap; rdata must keep its last loaded value.
        seg_base = 32'hFFFF_FF00;
        seg_limit = 32'h0000_0200;
        exp_bus.push_back('{addr: 32'h0000_0080, we: 1'b1, wdata: 32'hCAFE_F00D});
`ifdef MMU_ALIGN_CHECK_EN
        exp_d.push_back('{segv: 1'b0, chk_data: 1'b1, data: 32'h0});
`else
        exp_d.push_back('{segv: 1'b0, chk_data: 1'b1, data: 32'hFFFF_EFFD});
`endif
        data_op(1'b0, 1'b1, 32'h180, 32'hCAFE_F00D, 2, 2, 1'b0, 32'h0);

        // Fetch beyond the limit faults; a legal fetch then completes.
        seg_base = 32'h0000_1000;
        seg_limit = 32'h0000_0100;
        exp_i.push_back('{segv: 1'b1, chk_data: 1'b0, data: 32'h0});
        ready_lat = 1;
        @(posedge clk);
        #1;
        instr_req = 1'b1;
        pc = 32'h104;
        fetch_wait();
        @(posedge clk);
        @(negedge clk);
        check32("fetch_segv_cleared", {31'b0, instr_segv}, 32'h0);
        exp_bus.push_back('{addr: 32'h0000_1008, we: 1'b0, wdata: 32'h0});
        exp_i.push_back('{segv: 1'b0, chk_data: 1'b1, data: 32'hFFFF_EFF7});
        ready_lat = 2;
        @(posedge clk);
        #1;
        instr_req = 1'b1;
        pc = 32'h8;
        fetch_wait();
        repeat (3) @(posedge clk);
        @(negedge clk);

        check32("exp_bus_left", exp_bus.size(), 32'd0);
        check32("exp_d_left", exp_d.size(), 32'd0);
        check32("exp_i_left", exp_i.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
